cpu_sequencer: RTL and testbench

Phase sequencer for the accumulator CPU. It produces the 3-bit `phase` that drives the CPU controller (phases 0–7 per instruction). It supports free-run, single-step, halt on HLT, memory wait-state stalls and a stall watchdog, and it counts retired instructions. It sits between the debug/run control logic, the memory `ready` signal and the controller's `phase` input. The controller's `halt`, `rd` and `wr` outputs feed back into this block.

---
 rtl/cpu_sequencer.sv | 89 ++++++++
 tb/tb_cpu_sequencer.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: instruction phase sequencer with run/step/halt, memory stalls, watchdog and retire counter
module cpu_sequencer #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             step,
  input  logic             clr,
  input  logic             halt_req,
  input  logic             mem_rd,
  input  logic             mem_wr,
  input  logic             mem_ready,
  output logic [2:0]       phase,
  output logic             adv,
  output logic             busy,
  output logic             halted,
  output logic             err,
  output logic [CNT_W-1:0] instr_count
);
  typedef enum logic [1:0] {IDLE, RUN, STEP, HALTED} state_t;
  state_t state, state_n;
  logic [2:0] phase_n;
  logic [7:0] stall_cnt, stall_n;
  logic [CNT_W-1:0] cnt_n;
  logic err_n, stall, fault, halt_hit, wrap;
  assign busy = state == RUN || state == STEP;
  assign halted = state == HALTED;
  assign stall = busy && (mem_rd || mem_wr) && !mem_ready;
  assign adv = busy && !stall;
  assign fault = stall && stall_cnt == 8'(TIMEOUT - 1);
  assign halt_hit = adv && halt_req && phase == 3'd4;
  assign wrap = adv && phase == 3'd7;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      phase <= '0;
      stall_cnt <= '0;
      err <= 1'b0;
      instr_count <= '0;
    end else begin
      state <= state_n;
      phase <= phase_n;
      stall_cnt <= stall_n;
      err <= err_n;
      instr_count <= cnt_n;
    end
  end
  // fault outranks halt, halt outranks wrap, wrap outranks plain advance
  always_comb begin
    state_n = state;
    phase_n = phase;
    err_n = err;
    cnt_n = instr_count;
    stall_n = stall ? stall_cnt + 8'd1 : 8'd0;
    case (state)
      IDLE: begin
        phase_n = 3'd0;
        state_n = run ? RUN : step ? STEP : IDLE;
      end
      RUN, STEP: begin
        if (fault) begin
          state_n = HALTED;
          err_n = 1'b1;
          phase_n = 3'd0;
          stall_n = 8'd0;
        end else if (halt_hit) begin
          state_n = HALTED;
          phase_n = 3'd0;
          cnt_n = instr_count + CNT_W'(1);
        end else if (wrap) begin
          phase_n = 3'd0;
          cnt_n = instr_count + CNT_W'(1);
          state_n = (state == RUN && run) ? RUN : IDLE;
        end else if (adv) begin
          phase_n = phase + 3'd1;
        end
      end
      default: begin
        phase_n = 3'd0;
        if (clr) begin
          state_n = IDLE;
          err_n = 1'b0;
        end
      end
    endcase
  end
endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: directed self-checking bench for cpu_sequencer
module tb_cpu_sequencer;
  logic clk = 1'b0;
  logic rst, run, step, clr, halt_req, mem_rd, mem_wr, mem_ready;
  logic [2:0] phase;
  logic adv, busy, halted, err;
  logic [15:0] instr_count;
  int checks = 0;
  int passed = 0;
  cpu_sequencer #(.TIMEOUT(15), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .run(run), .step(step), .clr(clr),
    .halt_req(halt_req), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_ready(mem_ready),
    .phase(phase), .adv(adv), .busy(busy), .halted(halted), .err(err),
    .instr_count(instr_count)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  initial begin
    int ph3[11] = '{0, 1, 2, 3, 4, 5, 5, 5, 5, 6, 7};
    rst = 1; run = 0; step = 0; clr = 0; halt_req = 0; mem_rd = 0; mem_wr = 0; mem_ready = 1;
    repeat (2) @(negedge clk);
    check("rst_phase", 32'(phase), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_halted", 32'(halted), 0);
    check("rst_err", 32'(err), 0);
    check("rst_cnt", 32'(instr_count), 0);
    rst = 0; run = 1;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      check("run_phase", 32'(phase), 32'(i % 8));
      check("run_busy", 32'(busy), 1);
      if (i == 23) run = 0;
    end
    @(negedge clk);
    check("run_end_busy", 32'(busy), 0);
    check("run_end_phase", 32'(phase), 0);
    check("run_end_cnt", 32'(instr_count), 3);
    step = 1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      step = (i == 3);
      check("step_phase", 32'(phase), 32'(i));
      check("step_busy", 32'(busy), 1);
    end
    @(negedge clk);
    check("step_end_busy", 32'(busy), 0);
    check("step_end_cnt", 32'(instr_count), 4);
    @(negedge clk);
    check("step_stay_idle", 32'(busy), 0);
    check("step_idle_phase", 32'(phase), 0);
    run = 1;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      check("stall_phase", 32'(phase), 32'(ph3[i]));
      if (i >= 5 && i <= 7) begin mem_rd = 1; mem_ready = 0; end
      else begin mem_rd = 0; mem_ready = 1; end
      if (i == 10) run = 0;
      #1;
      check("stall_adv", 32'(adv), (i >= 5 && i <= 7) ? 0 : 1);
    end
    @(negedge clk);
    check("stall_end_busy", 32'(busy), 0);
    check("stall_end_cnt", 32'(instr_count), 5);
    run = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("halt_phase", 32'(phase), 32'(i));
      if (i >= 2) halt_req = 1;
    end
    @(negedge clk);
    check("halt_halted", 32'(halted), 1);
    check("halt_busy", 32'(busy), 0);
    check("halt_phase0", 32'(phase), 0);
    check("halt_cnt", 32'(instr_count), 6);
    step = 1;
    repeat (3) @(negedge clk);
    step = 0;
    check("halt_hold", 32'(halted), 1);
    check("halt_hold_busy", 32'(busy), 0);
    clr = 1;
    @(negedge clk);
    clr = 0; halt_req = 0;
    check("clr_halted", 32'(halted), 0);
    check("clr_busy", 32'(busy), 0);
    @(negedge clk);
    check("resume_busy", 32'(busy), 1);
    check("resume_phase", 32'(phase), 0);
    @(negedge clk);
    check("resume_phase1", 32'(phase), 1);
    @(negedge clk);
    check("drop_phase2", 32'(phase), 2);
    run = 0;
    for (int i = 3; i < 8; i++) begin
      @(negedge clk);
      check("drop_phase", 32'(phase), 32'(i));
      check("drop_busy", 32'(busy), 1);
    end
    @(negedge clk);
    check("drop_idle", 32'(busy), 0);
    check("drop_cnt", 32'(instr_count), 7);
    run = 1; mem_rd = 1; mem_ready = 0;
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      check("wd_busy", 32'(busy), 1);
      check("wd_halted", 32'(halted), 0);
      check("wd_phase", 32'(phase), 0);
    end
    @(negedge clk);
    check("wd_err", 32'(err), 1);
    check("wd_halted_set", 32'(halted), 1);
    check("wd_cnt", 32'(instr_count), 7);
    check("wd_phase0", 32'(phase), 0);
    run = 0; mem_rd = 0; mem_ready = 1;
    @(negedge clk);
    check("wd_err_hold", 32'(err), 1);
    clr = 1;
    @(negedge clk);
    clr = 0;
    check("wd_clr_err", 32'(err), 0);
    check("wd_clr_halted", 32'(halted), 0);
    run = 1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      check("rst_mid_phase", 32'(phase), 32'(i));
    end
    rst = 1;
    @(negedge clk);
    rst = 0; run = 0;
    check("rst_mid_phase0", 32'(phase), 0);
    check("rst_mid_cnt", 32'(instr_count), 0);
    check("rst_mid_busy", 32'(busy), 0);
    @(negedge clk);
    check("rst_mid_idle", 32'(busy), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
